pad_game_engine: RTL and testbench

PAD_GAME_ENGINE -- requirements
Module: pad_game_engine

---
 rtl/pad_game_engine.sv | 205 ++++++++++++++++++++
 tb/tb_pad_game_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_game_engine.sv
// -----------------------------------------------------------------------------
// pad_game_engine
//
// Whack-a-pad style game controller. A pseudo-random pad is armed (its lamp
// driven low) for a fixed window; the player scores by pressing that pad.
// A centre-zone press earns STRONG_PTS and a rim-only press earns WEAK_PTS.
// If the window expires without a press the target counts as a miss. A game
// lasts MAX_ROUNDS targets.
//
// Optional feature macro: PAD_GAME_MISS_PENALTY_EN
//   defined   -> a miss subtracts WEAK_PTS from the score (floored at 0)
//   undefined -> a miss leaves the score unchanged
//
// Ports
//   iVGA_CLK    in   sole clock, rising edge
//   iRST_n      in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a game from IDLE or OVER
//   abort       in   one-cycle pulse, ends play (returns to IDLE)
//   sensor_in   in   N_PADS*SENS_W active-low sensors, pad p at [p*SENS_W +: SENS_W]
//                    (MSB of each pad = centre zone, other bits = rim)
//   out_game    out  active-low target lamps, one per pad
//   target_idx  out  index of the armed pad
//   anim_phase  out  0 = not armed; 1..3 = thirds of the armed window
//   points      out  running score (saturating)
//   round_cnt   out  targets completed in the current game
//   active      out  game in progress (PICK, ARMED, SCORE)
//   game_over   out  game finished (OVER)
// -----------------------------------------------------------------------------
module pad_game_engine #(
  parameter int N_PADS     = 3,
  parameter int SENS_W     = 5,
  parameter int TIMEOUT    = 20000000,
  parameter int MAX_ROUNDS = 20,
  parameter int PTS_W      = 16,
  parameter int STRONG_PTS = 4,
  parameter int WEAK_PTS   = 2,
  localparam int IDX_W     = $clog2(N_PADS)
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_PADS*SENS_W-1:0]   sensor_in,
  output logic [N_PADS-1:0]          out_game,
  output logic [IDX_W-1:0]           target_idx,
  output logic [1:0]                 anim_phase,
  output logic [PTS_W-1:0]           points,
  output logic [7:0]                 round_cnt,
  output logic                       active,
  output logic                       game_over
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_ARMED = 3'd2,
    S_SCORE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_next;

  logic [N_PADS*SENS_W-1:0]   r_sensor_p0;
  logic [15:0]                r_lfsr;
  logic [CNT_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_target;
  logic [PTS_W-1:0]           r_points;
  logic [7:0]                 r_rounds;
  logic [PTS_W-1:0]           r_award;
  logic                       r_miss;

  logic [SENS_W-1:0]          w_pad;
  logic                       w_hit;
  logic                       w_strong;
  logic                       w_timeout;
  logic [7:0]                 w_rounds_inc;
  logic [PTS_W-1:0]           w_points_next;
  logic [15:0]                w_lfsr_next;
  logic                       w_start_game;
  logic                       w_score_commit;

  function automatic logic [PTS_W-1:0] sat_add(input logic [PTS_W-1:0] a,
                                               input logic [PTS_W-1:0] b);
    logic [PTS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PTS_W] ? {PTS_W{1'b1}} : sum[PTS_W-1:0];
  endfunction

`ifdef PAD_GAME_MISS_PENALTY_EN
  function automatic logic [PTS_W-1:0] sat_sub(input logic [PTS_W-1:0] a,
                                               input logic [PTS_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction
`endif

  // Stage p0: sensors are registered once; every hit decision uses this copy
  always_ff @(posedge iVGA_CLK) begin
    r_sensor_p0 <= sensor_in;
  end

  // Only the armed pad's sensors matter; other pads are never examined
  assign w_pad        = r_sensor_p0[r_target*SENS_W +: SENS_W];
  assign w_hit        = ~&w_pad;
  assign w_strong     = ~w_pad[SENS_W-1];
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rounds_inc = r_rounds + 8'd1;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), free-running
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

`ifdef PAD_GAME_MISS_PENALTY_EN
  assign w_points_next = r_miss ? sat_sub(r_points, PTS_W'(WEAK_PTS))
                                : sat_add(r_points, r_award);
`else
  assign w_points_next = r_miss ? r_points : sat_add(r_points, r_award);
`endif

  // Abort outranks start, hit and timeout in every non-IDLE state
  always_comb begin
    w_next = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE,
        S_OVER:  if (start) w_next = S_PICK;
        S_PICK:  w_next = S_ARMED;
        S_ARMED: if (w_hit || w_timeout) w_next = S_SCORE;
        S_SCORE: w_next = (w_rounds_inc == 8'(MAX_ROUNDS)) ? S_OVER : S_PICK;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_start_game   = ((r_state == S_IDLE) || (r_state == S_OVER)) && (w_next == S_PICK);
  // An abort arriving in SCORE discards that round's award
  assign w_score_commit = (r_state == S_SCORE) && (w_next != S_IDLE);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_lfsr   <= 16'hACE1;
      r_cnt    <= '0;
      r_target <= '0;
      r_points <= '0;
      r_rounds <= '0;
    end else begin
      r_lfsr <= w_lfsr_next;
      if (w_start_game) begin
        r_points <= '0;
        r_rounds <= '0;
      end
      if ((r_state == S_PICK) && (w_next == S_ARMED)) begin
        r_target <= IDX_W'(r_lfsr % 16'(N_PADS));
        r_cnt    <= '0;
      end else if ((r_state == S_ARMED) && (w_next == S_ARMED)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_score_commit) begin
        r_points <= w_points_next;
        r_rounds <= w_rounds_inc;
      end
    end
  end

  // Award is re-evaluated every armed cycle; the value from the final armed
  // cycle (the one that leaves ARMED) is what SCORE applies
  always_ff @(posedge iVGA_CLK) begin
    if (r_state == S_ARMED) begin
      r_award <= w_strong ? PTS_W'(STRONG_PTS) : PTS_W'(WEAK_PTS);
      r_miss  <= ~w_hit;
    end
  end

  always_comb begin
    out_game   = '1;
    anim_phase = 2'd0;
    if (r_state == S_ARMED) begin
      out_game[r_target] = 1'b0;
      if (r_cnt < CNT_W'(TIMEOUT / 3))
        anim_phase = 2'd1;
      else if (r_cnt < CNT_W'((2 * TIMEOUT) / 3))
        anim_phase = 2'd2;
      else
        anim_phase = 2'd3;
    end
  end

  assign target_idx = r_target;
  assign points     = r_points;
  assign round_cnt  = r_rounds;
  assign active     = (r_state == S_PICK) || (r_state == S_ARMED) || (r_state == S_SCORE);
  assign game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_pad_game_engine.sv
module tb_pad_game_engine;

  localparam int NP = 3;
  localparam int SW = 5;
  localparam int TO = 30;
  localparam int MR = 3;
  localparam int PW = 16;

`ifdef PAD_GAME_MISS_PENALTY_EN
  localparam int MISS_D = -2;
`else
  localparam int MISS_D = 0;
`endif

  localparam int ST_IDLE = 0, ST_PICK = 1, ST_ARMED = 2, ST_SCORE = 3, ST_OVER = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NP*SW-1:0]  sensor_in = '1;
  logic [NP-1:0]     out_game;
  logic [1:0]        target_idx;
  logic [1:0]        anim_phase;
  logic [PW-1:0]     points;
  logic [7:0]        round_cnt;
  logic              active;
  logic              game_over;

  pad_game_engine #(
    .N_PADS(NP), .SENS_W(SW), .TIMEOUT(TO), .MAX_ROUNDS(MR),
    .PTS_W(PW), .STRONG_PTS(4), .WEAK_PTS(2)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .start      (start),
    .abort      (abort),
    .sensor_in  (sensor_in),
    .out_game   (out_game),
    .target_idx (target_idx),
    .anim_phase (anim_phase),
    .points     (points),
    .round_cnt  (round_cnt),
    .active     (active),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural reference model ----------------
  int               m_st, m_cnt, m_tgt, m_pts, m_rnd, m_award;
  logic [15:0]      m_lfsr;
  logic [NP*SW-1:0] m_sens;
  logic [SW-1:0]    m_pad;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = ST_IDLE; m_cnt = 0; m_tgt = 0; m_pts = 0; m_rnd = 0; m_award = 0;
      m_lfsr = 16'hACE1; m_sens = '1;
    end else begin
      if (abort && m_st != ST_IDLE) begin
        m_st = ST_IDLE;
      end else if (m_st == ST_IDLE || m_st == ST_OVER) begin
        if (start) begin m_st = ST_PICK; m_pts = 0; m_rnd = 0; end
      end else if (m_st == ST_PICK) begin
        m_tgt = int'(m_lfsr) % NP; m_cnt = 0; m_st = ST_ARMED;
      end else if (m_st == ST_ARMED) begin
        m_pad = m_sens[m_tgt*SW +: SW];
        if (m_pad != '1) begin
          m_award = (m_pad[SW-1] == 1'b0) ? 4 : 2; m_st = ST_SCORE;
        end else if (m_cnt == TO - 1) begin
          m_award = MISS_D; m_st = ST_SCORE;
        end else begin
          m_cnt++;
        end
      end else if (m_st == ST_SCORE) begin
        m_pts = m_pts + m_award;
        if (m_pts < 0) m_pts = 0;
        if (m_pts > 65535) m_pts = 65535;
        m_rnd++;
        m_st = (m_rnd == MR) ? ST_OVER : ST_PICK;
      end
      m_sens = sensor_in;
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Per-cycle comparison of every output against the model
  logic [NP-1:0] e_og;
  logic [1:0]    e_ph;
  always @(negedge clk) begin
    if (chk_en) begin
      e_og = '1;
      if (m_st == ST_ARMED) e_og[m_tgt] = 1'b0;
      e_ph = (m_st != ST_ARMED) ? 2'd0 : (m_cnt < TO/3) ? 2'd1 : (m_cnt < 2*TO/3) ? 2'd2 : 2'd3;
      checks++;
      if (out_game !== e_og || target_idx !== 2'(m_tgt) || anim_phase !== e_ph ||
          points !== PW'(m_pts) || round_cnt !== 8'(m_rnd) ||
          active !== (m_st == ST_PICK || m_st == ST_ARMED || m_st == ST_SCORE) ||
          game_over !== (m_st == ST_OVER)) begin
        errors++;
        $display("FAIL model t=%0t got og=%b idx=%0d ph=%0d pts=%0d rnd=%0d act=%b go=%b want og=%b idx=%0d ph=%0d pts=%0d rnd=%0d st=%0d",
                 $time, out_game, target_idx, anim_phase, points, round_cnt, active, game_over,
                 e_og, m_tgt, e_ph, m_pts, m_rnd, m_st);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            other;     // 1: drive a non-target pad instead of the target
    logic [SW-1:0] pat;
    int            drive_at;  // window count at which the input is applied
    int            hold;      // cycles the pattern is held
    int            delta;     // expected score change
  } vec_t;

  vec_t vecs[7];
  int   e_pts, e_rnd;

  task automatic wait_armed();
    int n = 0;
    while (m_st != ST_ARMED && n < 10) begin @(negedge clk); n++; end
    if (m_st != ST_ARMED) chk("wait_armed", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int r0, left, pad;
    bit driven, done;
    logic [NP*SW-1:0] s;
    wait_armed();
    r0 = m_rnd; driven = 0; done = 0; left = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (!driven && m_st == ST_ARMED && m_cnt == v.drive_at) begin
        pad = v.other ? (m_tgt + 1) % NP : m_tgt;
        s = '1;
        s[pad*SW +: SW] = v.pat;
        sensor_in = s;
        driven = 1; left = v.hold;
      end
      @(negedge clk);
      if (driven && left > 0) begin
        left--;
        if (left == 0) sensor_in = '1;
      end
      if (m_rnd != r0) done = 1;
    end
    sensor_in = '1;
    chk($sformatf("vec%0d_done", id), 32'(done), 1);
    e_pts = e_pts + v.delta;
    if (e_pts < 0) e_pts = 0;
    e_rnd++;
    chk($sformatf("vec%0d_points", id), 32'(points), 32'(e_pts));
    chk($sformatf("vec%0d_rounds", id), 32'(round_cnt), 32'(e_rnd));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [NP*SW-1:0] rnd_s;
  bit quiet;

  initial begin
    vecs[0] = '{0, 5'b01111, 2,  1,  4};
    vecs[1] = '{0, 5'b11110, 5,  1,  2};
    vecs[2] = '{1, 5'b00000, 0,  29, MISS_D};
    vecs[3] = '{0, 5'b11111, 0,  1,  MISS_D};
    vecs[4] = '{0, 5'b10111, 28, 1,  2};
    vecs[5] = '{0, 5'b00000, 0,  1,  4};
    vecs[6] = '{0, 5'b01111, 3,  1,  4};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_game", 32'(out_game), 32'h7);
    chk("rst_target", 32'(target_idx), 0);
    chk("rst_phase", 32'(anim_phase), 0);
    chk("rst_points", 32'(points), 0);
    chk("rst_rounds", 32'(round_cnt), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_over", 32'(game_over), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Start latency: lamps all off after one edge, single lamp on after two
    pulse_start();
    chk("start_lamps_off", 32'(out_game), 32'h7);
    chk("start_active", 32'(active), 1);
    @(negedge clk);
    chk("armed_one_lamp", 32'($countones(out_game)), 2);
    chk("armed_phase1", 32'(anim_phase), 1);

    // Game 1
    e_pts = 0; e_rnd = 0;
    for (int i = 0; i < 3; i++) run_vec(vecs[i], i);
    chk("g1_game_over", 32'(game_over), 1);
    chk("g1_inactive", 32'(active), 0);

    // Game 2: restart clears score; miss first (floor), timeout-cycle hit, strong
    pulse_start();
    chk("g2_points_clear", 32'(points), 0);
    chk("g2_rounds_clear", 32'(round_cnt), 0);
    e_pts = 0; e_rnd = 0;
    for (int i = 3; i < 6; i++) run_vec(vecs[i], i);
    chk("g2_game_over", 32'(game_over), 1);

    // Game 3: score once, then abort+start together while armed
    pulse_start();
    e_pts = 0; e_rnd = 0;
    run_vec(vecs[6], 6);
    wait_armed();
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_lamps", 32'(out_game), 32'h7);
    chk("abort_active", 32'(active), 0);
    chk("abort_over", 32'(game_over), 0);
    chk("abort_points", 32'(points), 32'(e_pts));
    chk("abort_rounds", 32'(round_cnt), 32'(e_rnd));

    // Reset mid-game discards the game
    pulse_start();
    e_pts = 0; e_rnd = 0;
    run_vec(vecs[0], 7);
    wait_armed();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_points", 32'(points), 0);
    chk("midrst_rounds", 32'(round_cnt), 0);
    chk("midrst_lamps", 32'(out_game), 32'h7);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_phase", 32'(anim_phase), 0);
    #2 rst_n = 1'b1;

    // Randomized stimulus checked cycle-by-cycle against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      quiet = ((c / 400) % 2) == 1;
      start = ($urandom_range(0, 39) == 0);
      abort = ($urandom_range(0, 249) == 0);
      rnd_s = (NP*SW)'($urandom);
      sensor_in = (!quiet && $urandom_range(0, 5) == 0) ? rnd_s : '1;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; sensor_in = '1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
